// File: rtl/pbpix_rr_arbiter.sv
// Round-robin arbiter merging N pixel requesters into one single-entry buffered output channel.
// Latency: 1 cycle from grant (in_ack) to out_rdy; sustains 1 pixel/cycle when out_ack is held high.
// Backpressure: no grant while the buffer is full and not draining. Optional macro PBPIX_ZERO_SKIP_EN drops zero pixels and counts them.
module pbpix_rr_arbiter #(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int IDW = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [N-1:0]      in_rdy,
  output logic [N-1:0]      in_ack,
  input  logic [N-1:0]      in_zero,
  input  logic [N*DW-1:0]   in_data,
  output logic              out_rdy,
  input  logic              out_ack,
  output logic              out_zero,
  output logic [DW-1:0]     out_data,
  output logic [IDW-1:0]    out_id,
  output logic [15:0]       skip_cnt
);

  logic           valid;
  logic [IDW-1:0] ptr;
  logic           can_accept;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [DW-1:0]  grant_dat;
  logic           grant_zero;
  logic           load;

  assign out_rdy    = valid;
  assign can_accept = !valid || out_ack;

  // Rotating-priority scan starting at ptr, wrapping modulo N (N need not be a power of two).
  always_comb begin : grant_scan
    logic [IDW:0] cand;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!grant_vld && in_rdy[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
    if (!can_accept || !i_rstn) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    in_ack = '0;
    if (grant_vld) begin
      in_ack[grant_idx] = 1'b1;
    end
  end

  assign grant_dat  = in_data[int'(grant_idx)*DW +: DW];
  assign grant_zero = in_zero[grant_idx];

`ifdef PBPIX_ZERO_SKIP_EN
  logic        skip;
  logic [15:0] skip_q;

  assign load     = grant_vld && !grant_zero;
  assign skip     = grant_vld && grant_zero;
  assign skip_cnt = skip_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      skip_q <= '0;
    end else if (skip && (skip_q != 16'hFFFF)) begin
      skip_q <= skip_q + 16'd1;
    end
  end
`else
  assign load     = grant_vld;
  assign skip_cnt = '0;
`endif

  // Pointer advances on every grant, including skipped zero pixels.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr <= '0;
    end else if (grant_vld) begin
      if (grant_idx == IDW'(N-1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + IDW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid    <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_id   <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      out_data <= grant_dat;
      out_zero <= grant_zero;
      out_id   <= grant_idx;
    end else if (valid && out_ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pbpix_rr_arbiter.sv
// Directed bench for pbpix_rr_arbiter: per-cycle reference model plus literal sequence checks.
module tb_pbpix_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    in_rdy, in_ack, in_zero;
  logic [N*DW-1:0] in_data;
  logic            out_rdy, out_ack, out_zero;
  logic [DW-1:0]   out_data;
  logic [IDW-1:0]  out_id;
  logic [15:0]     skip_cnt;

  pbpix_rr_arbiter #(.N(N), .DW(DW), .IDW(IDW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .in_rdy(in_rdy), .in_ack(in_ack), .in_zero(in_zero), .in_data(in_data),
    .out_rdy(out_rdy), .out_ack(out_ack), .out_zero(out_zero),
    .out_data(out_data), .out_id(out_id), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, act[i], exp[i]);
  endtask

  // Reference model: integer pointer, buffered pixel, skip count
  int            m_ptr, m_id, m_skip;
  bit            m_vld, m_zero;
  logic [DW-1:0] m_data;
  int            nx_ptr, nx_id, nx_skip;
  bit            nx_vld, nx_zero;
  logic [DW-1:0] nx_data;
  int            g;
  logic [N-1:0]  exp_ack;
  bit            do_load;

  int            grant_ids[$];
  int            fwd_ids[$];
  int            fwd_zero[$];
  int            fwd_data[$];

  always begin
    @(negedge clk);
    if (!rstn) begin
      chk("rst_in_ack", in_ack, 0);
      chk("rst_out_rdy", out_rdy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_skip_cnt", skip_cnt, 0);
      nx_ptr = 0; nx_vld = 0; nx_data = '0; nx_zero = 0; nx_id = 0; nx_skip = 0;
    end else begin
      g = -1;
      if (!m_vld || out_ack) begin
        for (int i = 0; i < N; i++) begin
          if (g < 0 && in_rdy[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
      exp_ack = (g < 0) ? '0 : N'(1 << g);
      chk("in_ack", in_ack, exp_ack);
      chk("out_rdy", out_rdy, m_vld);
      if (m_vld) begin
        chk("out_data", out_data, m_data);
        chk("out_zero", out_zero, m_zero);
        chk("out_id", out_id, m_id);
      end
      chk("skip_cnt", skip_cnt, m_skip);
      if (m_vld && out_ack) begin
        fwd_ids.push_back(m_id);
        fwd_zero.push_back(int'(m_zero));
        fwd_data.push_back(int'(m_data));
      end
      nx_ptr = m_ptr; nx_vld = m_vld && !out_ack; nx_data = m_data;
      nx_zero = m_zero; nx_id = m_id; nx_skip = m_skip;
      if (g >= 0) begin
        grant_ids.push_back(g);
        nx_ptr = (g + 1) % N;
        do_load = 1'b1;
`ifdef PBPIX_ZERO_SKIP_EN
        if (in_zero[g]) begin
          do_load = 1'b0;
          if (nx_skip < 16'hFFFF) nx_skip = nx_skip + 1;
        end
`endif
        if (do_load) begin
          nx_vld = 1; nx_data = in_data[g*DW +: DW]; nx_zero = in_zero[g]; nx_id = g;
        end
      end
    end
    @(posedge clk);
    m_ptr = nx_ptr; m_vld = nx_vld; m_data = nx_data;
    m_zero = nx_zero; m_id = nx_id; m_skip = nx_skip;
  end

  // Drive one cycle of inputs shortly after the rising edge; data carries requester and cycle.
  task automatic drive(input logic [N-1:0] rdy, input logic [N-1:0] zero, input logic ack);
    @(posedge clk);
    #1;
    cyc++;
    in_rdy  = rdy;
    in_zero = zero;
    out_ack = ack;
    for (int k = 0; k < N; k++) in_data[k*DW +: DW] = 16'((k << 12) + (cyc & 12'hFFF));
    #1;
  endtask

  task automatic clear_logs();
    grant_ids.delete(); fwd_ids.delete(); fwd_zero.delete(); fwd_data.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0; in_rdy = '0; in_zero = '0; out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_logs();
  endtask

  int            e[$];
  logic [DW-1:0] held;

  initial begin
    rstn = 1'b0; in_rdy = '0; in_zero = '0; in_data = '0; out_ack = 1'b0;
    m_ptr = 0; m_vld = 0; m_data = '0; m_zero = 0; m_id = 0; m_skip = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_rdy", out_rdy, 0);
    chk("reset_in_ack", in_ack, 0);
    rstn = 1'b1;
    clear_logs();

    // Alternating requesters 0 and 2
    repeat (4) drive(4'b0101, '0, 1'b1);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    e = '{0, 2, 0, 2};
    chk_q("alt_grants", grant_ids, e);
    chk_q("alt_out_id", fwd_ids, e);

    // All requesters ready: strict rotation, no bubbles
    do_reset();
    repeat (6) drive(4'b1111, '0, 1'b1);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    e = '{0, 1, 2, 3, 0, 1};
    chk_q("rot_grants", grant_ids, e);
    chk_q("rot_out_id", fwd_ids, e);

    // Stall: buffer full, out_ack low
    do_reset();
    drive(4'b0010, '0, 1'b0);
    chk("stall_first_ack", in_ack, 4'b0010);
    drive(4'b0010, '0, 1'b0);
    held = out_data;
    chk("stall_held_data", held, 16'h1000 + 16'(cyc - 1));
    chk("stall_ack0", in_ack, 0);
    for (int i = 1; i < 5; i++) begin
      drive(4'b0010, '0, 1'b0);
      chk("stall_ack", in_ack, 0);
      chk("stall_data", out_data, held);
    end
    drive(4'b0010, '0, 1'b1);
    chk("stall_release_ack", in_ack, 4'b0010);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);

    // Zero pixels from requester 3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1000, (i < 3) ? 4'b1000 : 4'b0000, 1'b1);
      in_data[3*DW +: DW] = (i < 3) ? 16'h0000 : 16'h00AB;
    end
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
`ifdef PBPIX_ZERO_SKIP_EN
    chk("zs_skip_cnt", skip_cnt, 3);
    e = '{3};
    chk_q("zs_out_id", fwd_ids, e);
    e = '{16'h00AB};
    chk_q("zs_out_data", fwd_data, e);
`else
    chk("zs_skip_cnt", skip_cnt, 0);
    e = '{3, 3, 3, 3};
    chk_q("zs_out_id", fwd_ids, e);
    e = '{1, 1, 1, 0};
    chk_q("zs_out_zero", fwd_zero, e);
    e = '{0, 0, 0, 16'h00AB};
    chk_q("zs_out_data", fwd_data, e);
`endif

    // Reset while holding an undrained pixel
    do_reset();
    drive(4'b0001, '0, 1'b0);
    drive('0, '0, 1'b0);
    chk("pre_rst_out_rdy", out_rdy, 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    in_rdy = 4'b1000;
    #1;
    chk("async_rst_out_rdy", out_rdy, 0);
    chk("async_rst_in_ack", in_ack, 0);
    @(posedge clk);
    #1;
    clear_logs();
    rstn = 1'b1;
    in_rdy = 4'b1001;
    out_ack = 1'b1;
    #1;
    chk("post_rst_ack", in_ack, 4'b0001);
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    e = '{0};
    chk_q("post_rst_grant", grant_ids, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
